// File: rtl/r4_booth_seq_mult.sv
// ---------------------------------------------------------------------------
// r4_booth_seq_mult
//   Iterative radix-4 Booth multiplier. One Booth digit is retired per clock,
//   so a WIDTH x WIDTH signed product takes WIDTH/2 BUSY cycles. Operands are
//   accepted with a valid/ready handshake, and the product is delivered with one.
//
//   Optional build macro: R4MUL_UNSIGNED_EN. When defined, a tc input is added.
//   tc=1 gives signed operation. tc=0 zero-extends both operands and adds one
//   extra digit, so the product is unsigned.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_valid  operands valid
//   in_ready  block can accept operands (IDLE)
//   x, y      multiplicand / multiplier, two's complement
//   tc        (R4MUL_UNSIGNED_EN only) 1 = signed, 0 = unsigned, sampled on accept
//   out_valid product valid (DONE)
//   out_ready consumer accepts product
//   p         2*WIDTH-bit product, meaningful only while out_valid=1
//   busy      high while digits are being retired
// ---------------------------------------------------------------------------
module r4_booth_seq_mult #(
  parameter  int WIDTH = 24,
  localparam int CNT_W = $clog2(WIDTH/2+2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
`ifdef R4MUL_UNSIGNED_EN
  input  logic               tc,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_chk
    $error("r4_booth_seq_mult: WIDTH must be even and >= 4");
  end

  // The high half has two guard bits, so +-2x and the running sum never overflow.
  localparam int HI_W  = WIDTH + 2;
`ifdef R4MUL_UNSIGNED_EN
  // The multiplier is extended by two bits so that the extra unsigned digit sees
  // (0, 0, y[WIDTH-1]).
  localparam int LO_W  = WIDTH + 2;
`else
  localparam int LO_W  = WIDTH;
`endif
  localparam int CAT_W = HI_W + LO_W;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [HI_W-1:0]      xe_q, xe_d;     // extended multiplicand
  logic [HI_W-1:0]      hi_q, hi_d;     // accumulator high part
  logic [LO_W-1:0]      lo_q, lo_d;     // multiplier bits out, product bits in
  logic                 ym1_q, ym1_d;   // y[2i-1]
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
`ifdef R4MUL_UNSIGNED_EN
  logic                 tc_q, tc_d;
`endif

  // Booth recoding of the current triplet.
  logic            b_sgn, b_one, b_two;
  logic [HI_W-1:0] mag, sum;
  logic [CAT_W-1:0] cat, shf;
  logic [CNT_W-1:0] last_cnt;
  logic [2*WIDTH-1:0] p_sel;
  logic            sx, sy;
  logic            unused_hi;

  assign b_sgn = lo_q[1];
  assign b_one = lo_q[0] ^ ym1_q;
  assign b_two = (lo_q[1] & ~lo_q[0] & ~ym1_q) | (~lo_q[1] & lo_q[0] & ym1_q);
  assign mag   = b_one ? xe_q : (b_two ? {xe_q[HI_W-2:0], 1'b0} : '0);
  // The negation is exact: the operand is inverted and sgn enters as carry-in.
  assign sum   = hi_q + (mag ^ {HI_W{b_sgn}}) + {{(HI_W-1){1'b0}}, b_sgn};
  assign cat   = {sum, lo_q};
  assign shf   = $signed(cat) >>> 2;

`ifdef R4MUL_UNSIGNED_EN
  assign sx       = tc & x[WIDTH-1];
  assign sy       = tc & y[WIDTH-1];
  assign last_cnt = tc_q ? CNT_W'(WIDTH/2-1) : CNT_W'(WIDTH/2);
  // In signed mode, two leftover multiplier sign bits still sit below the product.
  assign p_sel    = tc_q ? shf[2*WIDTH+1:2] : shf[2*WIDTH-1:0];
  assign unused_hi = ^shf[CAT_W-1:2*WIDTH+2];
`else
  assign sx       = x[WIDTH-1];
  assign sy       = y[WIDTH-1];
  assign last_cnt = CNT_W'(WIDTH/2-1);
  assign p_sel    = shf[2*WIDTH-1:0];
  assign unused_hi = ^{sy, shf[CAT_W-1:2*WIDTH]};
`endif

  always_comb begin
    state_d = state_q;
    xe_d    = xe_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ym1_d   = ym1_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
`ifdef R4MUL_UNSIGNED_EN
    tc_d    = tc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          xe_d    = {{2{sx}}, x};
`ifdef R4MUL_UNSIGNED_EN
          lo_d    = {{2{sy}}, y};
          tc_d    = tc;
`else
          lo_d    = y;
`endif
          hi_d    = '0;
          ym1_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        hi_d  = shf[CAT_W-1:LO_W];
        lo_d  = shf[LO_W-1:0];
        ym1_d = lo_q[1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == last_cnt) begin
          p_d     = p_sel;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      xe_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ym1_q   <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
`ifdef R4MUL_UNSIGNED_EN
      tc_q    <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      xe_q    <= xe_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ym1_q   <= ym1_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
`ifdef R4MUL_UNSIGNED_EN
      tc_q    <= tc_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_BUSY);
  assign out_valid = (state_q == S_DONE);
  assign p         = p_q;

endmodule

// File: tb/tb_r4_booth_seq_mult.sv
// ---------------------------------------------------------------------------
// tb_r4_booth_seq_mult
//   This bench tests one WIDTH=24 instance and one WIDTH=8 instance of
//   r4_booth_seq_mult. It uses directed vectors with hand-computed products.
//   It also checks latency, the BUSY cycle count, backpressure and reset
//   during an operation.
// ---------------------------------------------------------------------------
module tb_r4_booth_seq_mult;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv24, rdy24, ov24, or24, busy24;
  logic [23:0] x24, y24;
  logic [47:0] p24;
  logic        iv8, rdy8, ov8, or8, busy8;
  logic [7:0]  x8, y8;
  logic [15:0] p8;
  logic        tc24, tc8;

  int n_tests = 0;
  int n_fail  = 0;

  r4_booth_seq_mult #(.WIDTH(24)) u24 (
    .clk(clk), .rst(rst), .in_valid(iv24), .in_ready(rdy24), .x(x24), .y(y24),
`ifdef R4MUL_UNSIGNED_EN
    .tc(tc24),
`endif
    .out_valid(ov24), .out_ready(or24), .p(p24), .busy(busy24));

  r4_booth_seq_mult #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .x(x8), .y(y8),
`ifdef R4MUL_UNSIGNED_EN
    .tc(tc8),
`endif
    .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mul24(input string tag, input logic [23:0] a, input logic [23:0] b,
                       input logic [47:0] exp);
    int n, nb;
    n = 0;
    while (!rdy24 && n < 100) begin @(posedge clk); #1; n++; end
    x24 = a; y24 = b; tc24 = 1'b1; iv24 = 1'b1;
    @(posedge clk); #1;
    iv24 = 1'b0;
    nb = busy24 ? 1 : 0;
    n  = 0;
    while (!ov24 && n < 100) begin
      @(posedge clk); #1; n++;
      if (busy24) nb++;
    end
    chk({tag, " lat"},   64'(n),  64'd12);
    chk({tag, " busy"},  64'(nb), 64'd12);
    chk({tag, " p"},     64'(p24), 64'(exp));
    if (or24) begin
      @(posedge clk); #1;
      chk({tag, " rdy"}, 64'(rdy24), 64'd1);
    end
  endtask

  task automatic mul8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic t, input logic [15:0] exp, input int lat);
    int n, nb;
    n = 0;
    while (!rdy8 && n < 100) begin @(posedge clk); #1; n++; end
    x8 = a; y8 = b; tc8 = t; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    nb = busy8 ? 1 : 0;
    n  = 0;
    while (!ov8 && n < 100) begin
      @(posedge clk); #1; n++;
      if (busy8) nb++;
    end
    chk({tag, " lat"},  64'(n),  64'(lat));
    chk({tag, " busy"}, 64'(nb), 64'(lat));
    chk({tag, " p"},    64'(p8), 64'(exp));
    if (or8) begin
      @(posedge clk); #1;
      chk({tag, " rdy"}, 64'(rdy8), 64'd1);
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    iv24 = 1'b0; x24 = '0; y24 = '0; or24 = 1'b1; tc24 = 1'b1;
    iv8  = 1'b0; x8  = '0; y8  = '0; or8  = 1'b1; tc8  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst p24",   64'(p24),    64'd0);
    chk("rst ov24",  64'(ov24),   64'd0);
    chk("rst rdy24", 64'(rdy24),  64'd1);
    chk("rst bsy24", 64'(busy24), 64'd0);
    chk("rst p8",    64'(p8),     64'd0);
    chk("rst ov8",   64'(ov8),    64'd0);
    chk("rst rdy8",  64'(rdy8),   64'd1);

    mul24("max*max",   24'h7FFFFF, 24'h7FFFFF, 48'h3FFFFF000001);
    mul24("-1*5",      24'hFFFFFF, 24'h000005, 48'hFFFFFFFFFFFB);
    mul24("min*min",   24'h800000, 24'h800000, 48'h400000000000);
    mul24("abc*123",   24'h000ABC, 24'h000123, 48'h0000000C33B4);

    mul8("8 min*min",  8'h80, 8'h80, 1'b1, 16'h4000, 4);
    mul8("8 3*-3",     8'h03, 8'hFD, 1'b1, 16'hFFF7, 4);
    mul8("8 7f*7f",    8'h7F, 8'h7F, 1'b1, 16'h3F01, 4);
    mul8("8 -5*7",     8'hFB, 8'h07, 1'b1, 16'hFFDD, 4);
    mul8("8 0*55",     8'h00, 8'h55, 1'b1, 16'h0000, 4);

    // Backpressure: the product must stay put while DONE waits for out_ready.
    or8 = 1'b0;
    mul8("bp", 8'h05, 8'h06, 1'b1, 16'h001E, 4);
    for (int i = 0; i < 10; i++) begin
      iv8 = i[0]; x8 = 8'h11; y8 = 8'h22;
      @(posedge clk); #1;
      chk("bp ov",  64'(ov8),  64'd1);
      chk("bp p",   64'(p8),   64'h1E);
      chk("bp rdy", 64'(rdy8), 64'd0);
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    chk("bp ov0",  64'(ov8),   64'd0);
    chk("bp rdy1", 64'(rdy8),  64'd1);
    chk("bp idle", 64'(busy8), 64'd0);
    @(posedge clk); #1;
    chk("bp noacc", 64'(busy8), 64'd0);

    // Reset mid-operation during BUSY cycle 3.
    while (!rdy24) begin @(posedge clk); #1; end
    x24 = 24'h000100; y24 = 24'h000100; iv24 = 1'b1;
    @(posedge clk); #1;
    iv24 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst rdy", 64'(rdy24),  64'd1);
    chk("mrst ov",  64'(ov24),   64'd0);
    chk("mrst p",   64'(p24),    64'd0);
    chk("mrst bsy", 64'(busy24), 64'd0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (ov24) cnt++;
    end
    chk("mrst noov", 64'(cnt), 64'd0);
    mul24("post rst", 24'h000100, 24'h000100, 48'h000000010000);

`ifdef R4MUL_UNSIGNED_EN
    mul8("u ff*ff",  8'hFF, 8'hFF, 1'b0, 16'hFE01, 5);
    mul8("s ff*ff",  8'hFF, 8'hFF, 1'b1, 16'h0001, 4);
    mul8("u 80*80",  8'h80, 8'h80, 1'b0, 16'h4000, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/r4_booth_seq_mult.md
Name: r4_booth_seq_mult

Overview:
- Iterative, parametrised radix-4 Booth multiplier: N x N bits in, 2N-bit product out.
- Retires one Booth digit per clock, so a full product takes N/2 cycles.
- Reuses the radix-4 recoding rule (sign/one/two from an overlapping bit triplet) of the combinational partial-product generators.
- Replaces the fixed 24-bit bit-matrix approach for area-constrained datapaths; valid/ready handshake on both sides.

Parameters:
- WIDTH, 24, operand width in bits; must be even and >= 4 (elaboration error otherwise).
- CNT_W, $clog2(WIDTH/2+2), digit counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- x  input  WIDTH  multiplicand, two's complement
- y  input  WIDTH  multiplier, two's complement
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- p  output  2*WIDTH  product
- busy  output  1  high in BUSY state

Behaviour:
- Reset: synchronous on rst=1 at a clk edge. State=IDLE, out_valid=0, p=0, counter=0, busy=0; in_ready=1 from the first cycle after reset.
- rst mid-operation aborts the current product and discards it; no out_valid is produced.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE), combinational. busy = (state==BUSY). out_valid = (state==DONE), registered.
- IDLE: on in_valid & in_ready, latch x (sign-extended to WIDTH+2) and y, clear the accumulator and y[-1], set counter=0, go to BUSY. in_valid without in_ready is ignored.
- BUSY, per cycle for digit i:
  - Triplet (y[2i+1], y[2i], y[2i-1]) with y[-1]=0.
  - sign = y[2i+1]; one = y[2i] ^ y[2i-1]; two = (y[2i+1] & ~y[2i] & ~y[2i-1]) | (~y[2i+1] & y[2i] & y[2i-1]).
  - pp = {0, +-x, +-2x} as a WIDTH+2-bit signed value. Negation is done exactly (one's complement plus carry-in 1) inside the cycle; no deferred sign bits.
  - acc_hi = acc_hi + pp; {acc_hi, acc_lo} then shifts arithmetically right by 2; multiplier bits shift out as product bits shift in.
  - counter++.
- After the last digit (counter reaches WIDTH/2-1 that cycle), go to DONE. p is loaded with the low 2*WIDTH bits of {acc_hi, acc_lo}.
- Latency: accept at edge E0; out_valid=1 after edge E0+WIDTH/2; exactly WIDTH/2 BUSY cycles.
- DONE: hold p and out_valid stable while out_ready=0, with no limit. On out_valid & out_ready at an edge: out_valid->0, state->IDLE. in_ready rises the following cycle; no overlap of accept and deliver.
- Throughput: one product per WIDTH/2+2 cycles with out_ready tied high.
- Arithmetic: result exactly equals x*y as a signed 2*WIDTH-bit value for all inputs, including x=y=-2^(WIDTH-1). The accumulator is WIDTH+2 bits wide so no intermediate overflow occurs.
- p holds its last value in IDLE/BUSY; it is valid only when out_valid=1.

Optional Feature:
- Macro R4MUL_UNSIGNED_EN.
- Defined:
  - Adds input port tc (1 bit), sampled on accept.
  - tc=1: signed behaviour as above.
  - tc=0: x and y are zero-extended to WIDTH+2 bits and one extra Booth digit is processed. BUSY lasts WIDTH/2+1 cycles; p = unsigned x*y.
- Not defined: no tc port; always signed, WIDTH/2 BUSY cycles.

Test Plan:
- WIDTH=24, x=0x7FFFFF, y=0x7FFFFF, out_ready=1 -> p=0x3FFFFF000001; out_valid asserts exactly 12 edges after accept.
- WIDTH=24, x=0xFFFFFF (-1), y=5 -> p=0xFFFFFFFFFFFB; then x=0x800000, y=0x800000 -> p=0x400000000000.
- WIDTH=8, x=0x80, y=0x80 -> p=0x4000. Also x=0x03, y=0xFD -> p=0xFFF7; covers two, +-one and zero digits.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> p and out_valid stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> one handshake, in_ready=1 next cycle.
- Reset mid-op: assert rst at BUSY cycle 3 -> next cycle state IDLE, out_valid=0, p=0, in_ready=1. A new operation then completes correctly.
- R4MUL_UNSIGNED_EN, WIDTH=8, tc=0, x=0xFF, y=0xFF -> p=0xFE01 after 5 BUSY cycles. Same operands with tc=1 -> p=0x0001 after 4 BUSY cycles.
